// File: rtl/dds_mode_pkg.sv
// dds_mode_pkg: shared mode encodings and sequencer state for the DDS mode controller
package dds_mode_pkg;
    localparam int MODE_W = 3;
    typedef logic [MODE_W-1:0] mode_t;
    localparam mode_t MODE_SIN  = 3'd0;
    localparam mode_t MODE_AM   = 3'd1;
    localparam mode_t MODE_FM   = 3'd2;
    localparam mode_t MODE_PM   = 3'd3;
    localparam mode_t MODE_ASK  = 3'd4;
    localparam mode_t MODE_FSK  = 3'd5;
    localparam mode_t MODE_PSK  = 3'd6;
    localparam mode_t MODE_LAST = MODE_PSK;
    localparam mode_t MODE_BAD  = 3'd7;
    typedef enum logic [1:0] {ST_IDLE, ST_MUTE, ST_SWITCH, ST_SETTLE} state_e;
    function automatic mode_t scan_next(input mode_t m);
        return (m == MODE_LAST) ? MODE_SIN : m + 3'd1;
    endfunction
endpackage

// File: rtl/dds_dwell_timer.sv
// dds_dwell_timer: free-running dwell counter with enable, restart and terminal pulse
module dds_dwell_timer #(
    parameter logic [31:0] DWELL_CYCLES = 32'd100_000_000
) (
    input  logic clk_100M,
    input  logic rst_n,
    input  logic en,
    input  logic restart,
    output logic tick
);
    logic [31:0] cnt_q, cnt_d;
    always_comb begin
        tick  = en && !restart && (cnt_q == DWELL_CYCLES - 32'd1);
        cnt_d = (tick || restart || !en) ? 32'd0 : cnt_q + 32'd1;
    end
    always_ff @(posedge clk_100M or negedge rst_n) begin
        if (!rst_n) cnt_q <= 32'd0;
        else        cnt_q <= cnt_d;
    end
endmodule

// File: rtl/dds_mode_ctrl.sv
// dds_mode_ctrl: glitch-free DDS mode switch sequencer; DDS_MODE_AUTOSCAN_EN adds dwell-timed auto-scan
module dds_mode_ctrl
    import dds_mode_pkg::*;
#(
    parameter int unsigned MUTE_CYCLES   = 16,
    parameter int unsigned SETTLE_CYCLES = 64
`ifdef DDS_MODE_AUTOSCAN_EN
    ,
    parameter logic [31:0] DWELL_CYCLES  = 32'd100_000_000
`endif
) (
    input  logic              clk_100M,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic [MODE_W-1:0] req_mode,
    output logic              req_ready,
`ifdef DDS_MODE_AUTOSCAN_EN
    input  logic              scan_en,
`endif
    output logic [MODE_W-1:0] mode,
    output logic              mute,
    output logic              phase_clr,
    output logic              busy,
    output logic              err
);
    localparam logic [15:0] MUTE_LOAD   = 16'(MUTE_CYCLES - 1);
    localparam logic [15:0] SETTLE_LOAD = 16'(SETTLE_CYCLES - 1);
    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    mode_t       pending_q, pending_d;
    mode_t       mode_q, mode_d;
    logic        mute_q, mute_d;
    logic        phase_clr_q, phase_clr_d;
    logic        busy_q, busy_d;
    logic        err_q, err_d;
    logic        req_go;
    mode_t       req_sel;
    assign req_ready = (state_q == ST_IDLE);
`ifdef DDS_MODE_AUTOSCAN_EN
    logic dwell_en, dwell_restart, dwell_tick;
    assign dwell_en      = scan_en && (state_q == ST_IDLE);
    assign dwell_restart = req_valid && req_ready;
    dds_dwell_timer #(.DWELL_CYCLES(DWELL_CYCLES)) u_dwell (
        .clk_100M (clk_100M),
        .rst_n    (rst_n),
        .en       (dwell_en),
        .restart  (dwell_restart),
        .tick     (dwell_tick)
    );
    // an external request in the terminal cycle takes priority over the scan step
    assign req_go  = req_valid || dwell_tick;
    assign req_sel = req_valid ? req_mode : scan_next(mode_q);
`else
    assign req_go  = req_valid;
    assign req_sel = req_mode;
`endif
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pending_d   = pending_q;
        mode_d      = mode_q;
        phase_clr_d = 1'b0;
        err_d       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_go && req_ready) begin
                    if (req_sel == MODE_BAD) begin
                        err_d = 1'b1;
                    end else if (req_sel != mode_q) begin
                        pending_d = req_sel;
                        cnt_d     = MUTE_LOAD;
                        state_d   = ST_MUTE;
                    end
                end
            end
            ST_MUTE: begin
                if (cnt_q == 16'd0) state_d = ST_SWITCH;
                else                cnt_d   = cnt_q - 16'd1;
            end
            ST_SWITCH: begin
                mode_d      = pending_q;
                phase_clr_d = 1'b1;
                cnt_d       = SETTLE_LOAD;
                state_d     = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (cnt_q == 16'd0) state_d = ST_IDLE;
                else                cnt_d   = cnt_q - 16'd1;
            end
            default: state_d = ST_IDLE;
        endcase
        // mute trails the state by one cycle; busy spans acceptance through unmute
        mute_d = (state_q != ST_IDLE);
        busy_d = (state_q != ST_IDLE) || (state_d != ST_IDLE);
    end
    always_ff @(posedge clk_100M or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 16'd0;
            pending_q   <= MODE_SIN;
            mode_q      <= MODE_SIN;
            mute_q      <= 1'b0;
            phase_clr_q <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pending_q   <= pending_d;
            mode_q      <= mode_d;
            mute_q      <= mute_d;
            phase_clr_q <= phase_clr_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
        end
    end
    assign mode      = mode_q;
    assign mute      = mute_q;
    assign phase_clr = phase_clr_q;
    assign busy      = busy_q;
    assign err       = err_q;
endmodule

// File: tb/tb_dds_mode_ctrl.sv
// tb_dds_mode_ctrl: scoreboard bench for dds_mode_ctrl; auto-scan cases build with DDS_MODE_AUTOSCAN_EN
module tb_dds_mode_ctrl;
    localparam int M = 16;
    localparam int S = 64;
    localparam int EV_CLR = 0, EV_ERR = 1, EV_UNMUTE = 2;
    typedef struct {int kind; int val; int due;} exp_t;
    logic       clk_100M = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic [2:0] req_mode = 3'd0;
    logic       req_ready;
    logic       scan_en = 1'b0;
    logic [2:0] mode;
    logic       mute, phase_clr, busy, err;
    exp_t       q[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    dds_mode_ctrl #(
        .MUTE_CYCLES(M),
        .SETTLE_CYCLES(S)
`ifdef DDS_MODE_AUTOSCAN_EN
        ,
        .DWELL_CYCLES(32'd100)
`endif
    ) dut (
        .clk_100M  (clk_100M),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_mode  (req_mode),
        .req_ready (req_ready),
`ifdef DDS_MODE_AUTOSCAN_EN
        .scan_en   (scan_en),
`endif
        .mode      (mode),
        .mute      (mute),
        .phase_clr (phase_clr),
        .busy      (busy),
        .err       (err)
    );
    always #5 clk_100M = ~clk_100M;
    always @(posedge clk_100M) cyc <= cyc + 1;
    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
        end
    endtask
    task automatic see(input int k, input int v);
        exp_t e;
        checks++;
        if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: kind=%0d mode=%0d cyc=%0d", k, v, cyc);
        end else begin
            e = q.pop_front();
            if (e.kind != k || e.val != v || e.due != cyc) begin
                errors++;
                $display("FAIL event: got kind=%0d mode=%0d cyc=%0d expected kind=%0d mode=%0d cyc=%0d",
                         k, v, cyc, e.kind, e.val, e.due);
            end
        end
    endtask
    // monitor: every phase_clr pulse, err pulse and mute fall must match the queue head
    initial begin
        int prev_mute;
        prev_mute = 0;
        forever begin
            @(negedge clk_100M);
            if (!rst_n) begin
                prev_mute = 0;
            end else begin
                if (phase_clr) see(EV_CLR, int'(mode));
                if (err) see(EV_ERR, int'(mode));
                if (prev_mute == 1 && !mute) see(EV_UNMUTE, int'(mode));
                prev_mute = int'(mute);
            end
        end
    end
    task automatic exp_seq(input int m, input int acc);
        q.push_back('{EV_CLR, m, acc + M + 1});
        q.push_back('{EV_UNMUTE, m, acc + M + S + 2});
    endtask
    task automatic send(input logic [2:0] m, output int acc);
        int n;
        n = 0;
        acc = -1;
        req_valid = 1'b1;
        req_mode = m;
        @(negedge clk_100M);
        while (!req_ready && n < 300) begin
            n++;
            @(negedge clk_100M);
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got ready=0 expected ready=1 (mode %0d)", m);
        end else begin
            acc = cyc + 1;
        end
        @(posedge clk_100M);
        #1 req_valid = 1'b0;
    endtask
    task automatic wait_cyc(input int t);
        while (cyc < t) begin
            @(posedge clk_100M);
            #1;
        end
    endtask
    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 300) begin
            n++;
            @(posedge clk_100M);
            #1;
        end
        chk("idle_wait", int'(busy), 0);
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
    initial begin
        int acc, acc2, c0, n;
        repeat (3) @(posedge clk_100M);
        #1;
        chk("rst_mode", int'(mode), 0);
        chk("rst_mute", int'(mute), 0);
        chk("rst_phase_clr", int'(phase_clr), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_ready", int'(req_ready), 1);
        rst_n = 1'b1;
        repeat (2) @(posedge clk_100M);
        #1;
        send(3'd2, acc);
        exp_seq(2, acc);
        chk("busy_at_accept", int'(busy), 1);
        chk("mute_at_accept", int'(mute), 0);
        @(posedge clk_100M);
        #1;
        chk("mute_rise", int'(mute), 1);
        n = 1;
        while (busy && n < 200) begin
            n++;
            @(posedge clk_100M);
            #1;
        end
        chk("busy_len", n, M + S + 2);
        chk("mode_after_seq", int'(mode), 2);
        chk("ready_after_seq", int'(req_ready), 1);
        send(3'd7, acc);
        q.push_back('{EV_ERR, 2, acc});
        @(posedge clk_100M);
        #1;
        chk("err_single", int'(err), 0);
        chk("err_busy", int'(busy), 0);
        chk("err_mute", int'(mute), 0);
        chk("err_mode", int'(mode), 2);
        c0 = cyc;
        send(3'd2, acc);
        chk("same_accept_lat", acc, c0 + 1);
        chk("same_busy", int'(busy), 0);
        repeat (5) @(posedge clk_100M);
        #1;
        chk("same_mute", int'(mute), 0);
        chk("same_mode", int'(mode), 2);
        send(3'd1, acc);
        exp_seq(1, acc);
        wait_cyc(acc + 30);
        chk("settle_ready", int'(req_ready), 0);
        send(3'd5, acc2);
        exp_seq(5, acc2);
        chk("b2b_accept", acc2, acc + M + S + 2);
        wait_idle();
        chk("b2b_mode", int'(mode), 5);
        send(3'd3, acc);
        wait_cyc(acc + 5);
        chk("mid_mute", int'(mute), 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_mode", int'(mode), 0);
        chk("mid_rst_mute", int'(mute), 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_clr", int'(phase_clr), 0);
        repeat (3) @(posedge clk_100M);
        #1 rst_n = 1'b1;
        repeat (30) @(posedge clk_100M);
        #1;
        chk("post_rst_mode", int'(mode), 0);
        chk("post_rst_ready", int'(req_ready), 1);
`ifdef DDS_MODE_AUTOSCAN_EN
        send(3'd6, acc);
        exp_seq(6, acc);
        wait_idle();
        chk("scan_start_mode", int'(mode), 6);
        scan_en = 1'b1;
        acc = cyc + 100;
        exp_seq(0, acc);
        wait_cyc(acc + 1);
        chk("scan_busy", int'(busy), 1);
        wait_cyc(acc + M + S + 1 + 99);
        req_valid = 1'b1;
        req_mode = 3'd3;
        @(posedge clk_100M);
        #1 req_valid = 1'b0;
        exp_seq(3, cyc);
        chk("scan_ext_busy", int'(busy), 1);
        scan_en = 1'b0;
        wait_idle();
        chk("scan_ext_mode", int'(mode), 3);
`endif
        repeat (5) @(posedge clk_100M);
        #1;
        chk("queue_drained", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
